loop_stack: RTL
===============

Name: loop_stack

Overview:
- Parametrised successor to the core's loop-address stack.
- LIFO holding '[' return addresses for the Brainfuck sequencer. Adds full/empty flags, occupancy count, sticky overflow/underflow errors, simultaneous push+pop (replace-top), and a TOP output that is always valid.
- Sits between the instruction decoder (PUSH on '[', POP on ']') and the PC-load mux.

Parameters:
- WIDTH, 11, bits per entry (program address width)
- DEPTH_POW, 7, log2 of entry count
- DEPTH, 1 << DEPTH_POW, entry count (derived; do not override)

Ports:
- CLK  input  1  clock
- RESET  input  1  reset, synchronous, active-high
- PUSH  input  1  push D this cycle
- POP  input  1  pop top this cycle
- D  input  WIDTH  data to push
- ERR_CLR  input  1  clears OVERFLOW/UNDERFLOW
- TOP  output  WIDTH  current top-of-stack; 0 when empty
- COUNT  output  DEPTH_POW+1  number of stored entries, 0..DEPTH
- EMPTY  output  1  COUNT == 0
- FULL  output  1  COUNT == DEPTH
- OVERFLOW  output  1  sticky: push attempted while full
- UNDERFLOW  output  1  sticky: pop attempted while empty

Behaviour:
- All outputs are registered or decoded from registers. Effects appear in the cycle after the sampling edge; one-cycle latency, back-to-back ops allowed every cycle.
- Reset: COUNT=0, TOP=0, EMPTY=1, FULL=0, OVERFLOW=0, UNDERFLOW=0. Memory contents are not cleared. RESET overrides every other input, including mid-sequence.
- Storage: TOP lives in a register; entries below it live in a DEPTH-1 entry array at index COUNT-2. The array uses asynchronous read, mapping to distributed RAM.
- PUSH only, not FULL:
  - if COUNT>0, array[COUNT-1] <= TOP
  - TOP <= D, COUNT <= COUNT+1
- PUSH only, FULL: state unchanged; OVERFLOW <= 1.
- POP only, not EMPTY:
  - TOP <= array[COUNT-2] if COUNT>=2, else 0
  - COUNT <= COUNT-1
- POP only, EMPTY: state unchanged; UNDERFLOW <= 1.
- PUSH and POP together, not EMPTY: replace-top. TOP <= D, COUNT unchanged. Legal when FULL; no overflow.
- PUSH and POP together, EMPTY: state unchanged; UNDERFLOW <= 1.
- Neither asserted: hold.
- ERR_CLR clears both sticky flags. A new error event in the same cycle wins, and its flag is set.
- COUNT arithmetic is DEPTH_POW+1 bits and never wraps. Saturation is enforced by the FULL/EMPTY guards above.
- FULL and EMPTY decode from COUNT only; there is no separate flag state.

Decomposition:
- Shared package (bf_pkg) holds:
  - ADDR_WIDTH=11 and LOOP_DEPTH_POW=7 defaults, shared with the PC and decoder
  - a stack_op encoding {NOP, PUSH, POP, REPLACE} used by the decoder and the bench
- Natural sub-module: loop_stack_ram, a DEPTH-1 x WIDTH memory with a synchronous write port and an asynchronous read port. The control, TOP register and flags stay in loop_stack.

Test Plan:
- Reset then PUSH 0x005, 0x123, 0x7FF on consecutive cycles -> TOP=0x7FF, COUNT=3. Then three POPs -> TOP 0x123, 0x005, 0; EMPTY=1 after the last pop.
- Fill with DEPTH pushes of value i (0..127) -> FULL=1, TOP=127. A 129th PUSH of 0x555 -> OVERFLOW=1, TOP=127, COUNT=128.
- POP while EMPTY -> UNDERFLOW=1, COUNT=0, TOP=0. ERR_CLR the next cycle -> UNDERFLOW=0. ERR_CLR asserted together with a bad POP -> UNDERFLOW stays 1.
- COUNT=2 (0x010, 0x020), assert PUSH+POP with D=0x030 -> TOP=0x030, COUNT=2. A POP then gives TOP=0x010. Repeat replace-top while FULL -> no OVERFLOW.
- Push 4 entries, assert RESET in the same cycle as a PUSH -> COUNT=0, TOP=0, flags cleared. A subsequent PUSH 0x001 -> TOP=0x001, COUNT=1.
- Random push/pop/replace sequence of 10k cycles, compared against a queue reference model -> TOP, COUNT, FULL, EMPTY and error flags match every cycle.

Source files
------------

// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared Brainfuck core defaults and stack op encoding
package bf_pkg;

  localparam int ADDR_WIDTH     = 11;
  localparam int LOOP_DEPTH_POW = 7;

  // Encoded as {push, pop} so the decoder can drive the two strobes directly.
  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    return stack_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/loop_stack_if.sv
// rtl/loop_stack_if.sv - decoder-facing port bundle of the loop-address stack
interface loop_stack_if
  import bf_pkg::*;
#(
  parameter int WIDTH     = ADDR_WIDTH,
  parameter int DEPTH_POW = LOOP_DEPTH_POW
);

  logic                 PUSH;
  logic                 POP;
  logic [WIDTH-1:0]     D;
  logic                 ERR_CLR;
  logic [WIDTH-1:0]     TOP;
  logic [DEPTH_POW:0]   COUNT;
  logic                 EMPTY;
  logic                 FULL;
  logic                 OVERFLOW;
  logic                 UNDERFLOW;

  modport master (
    output PUSH, POP, D, ERR_CLR,
    input  TOP, COUNT, EMPTY, FULL, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  PUSH, POP, D, ERR_CLR,
    output TOP, COUNT, EMPTY, FULL, OVERFLOW, UNDERFLOW
  );

endinterface

// File: rtl/loop_stack_ram.sv
// rtl/loop_stack_ram.sv - entries below top-of-stack; sync write, async read
module loop_stack_ram #(
  parameter int WIDTH   = 11,
  parameter int ENTRIES = 127,
  parameter int AW      = 7
) (
  input  logic             CLK,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [ENTRIES];

  always_ff @(posedge CLK) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/loop_stack.sv
// rtl/loop_stack.sv - LIFO of '[' return addresses with registered top and sticky errors
module loop_stack
  import bf_pkg::*;
#(
  parameter int WIDTH     = ADDR_WIDTH,
  parameter int DEPTH_POW = LOOP_DEPTH_POW,
  localparam int DEPTH    = 1 << DEPTH_POW
) (
  input  logic       CLK,
  input  logic       RESET,
  loop_stack_if.slave bus
);

  localparam logic [DEPTH_POW:0]   CNT_ONE  = (DEPTH_POW+1)'(1);
  localparam logic [DEPTH_POW:0]   CNT_TWO  = (DEPTH_POW+1)'(2);
  localparam logic [DEPTH_POW:0]   CNT_FULL = (DEPTH_POW+1)'(DEPTH);
  localparam logic [DEPTH_POW-1:0] ADR_ONE  = DEPTH_POW'(1);
  localparam logic [DEPTH_POW-1:0] ADR_TWO  = DEPTH_POW'(2);

  logic [WIDTH-1:0]     top_q, top_d;
  logic [DEPTH_POW:0]   count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 empty, full;
  logic                 ram_we;
  logic [DEPTH_POW-1:0] ram_waddr, ram_raddr;
  logic [WIDTH-1:0]     ram_rdata;
  stack_op_e            op;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign op    = decode_op(bus.PUSH, bus.POP);

  // The entry just below the top sits at COUNT-2; pushing spills TOP into COUNT-1.
  assign ram_waddr = count_q[DEPTH_POW-1:0] - ADR_ONE;
  assign ram_raddr = (count_q >= CNT_TWO) ? count_q[DEPTH_POW-1:0] - ADR_TWO : '0;

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    ovf_d   = bus.ERR_CLR ? 1'b0 : ovf_q;
    unf_d   = bus.ERR_CLR ? 1'b0 : unf_q;
    ram_we  = 1'b0;
    unique case (op)
      OP_PUSH: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          ram_we  = !empty;
          top_d   = bus.D;
          count_d = count_q + CNT_ONE;
        end
      end
      OP_POP: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          top_d   = (count_q >= CNT_TWO) ? ram_rdata : '0;
          count_d = count_q - CNT_ONE;
        end
      end
      OP_REPLACE: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          top_d = bus.D;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  loop_stack_ram #(
    .WIDTH   (WIDTH),
    .ENTRIES (DEPTH - 1),
    .AW      (DEPTH_POW)
  ) u_ram (
    .CLK     (CLK),
    .we_i    (ram_we && !RESET),
    .waddr_i (ram_waddr),
    .wdata_i (top_q),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign bus.TOP       = top_q;
  assign bus.COUNT     = count_q;
  assign bus.EMPTY     = empty;
  assign bus.FULL      = full;
  assign bus.OVERFLOW  = ovf_q;
  assign bus.UNDERFLOW = unf_q;

endmodule
